// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Produces Decode/Execute forwarding selects, stall/flush controls for
// load-use, branch/jr-in-Decode, taken-jump and HI/LO hazards, and tracks
// the multi-cycle mult/div unit with a small IDLE/BUSY FSM.
// Ports:
//   clock, reset_n              : rising-edge clock, async active-low reset
//   reg_rs/rt_id_D/E            : source register indices in Decode/Execute
//   write_reg_E/M/W, reg_write_*: destination index and write enable per stage
//   mem_to_reg_E/M              : load in Execute/Memory
//   branch_D, jump_reg_D, jump_D: control-flow instruction info in Decode
//   hilo_use_D                  : Decode instruction touches HI/LO
//   muldiv_start_E/is_div_E     : mult/div issue in Execute
//   stall_F/D, flush_D/E        : pipeline register controls
//   forward_a/b_D, forward_a/b_E: forwarding selects
//   muldiv_busy                 : mult/div in progress
module hazard_controller #(
    parameter int unsigned MULT_LATENCY = 4,
    parameter int unsigned DIV_LATENCY  = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] reg_rs_id_D,
    input  logic [4:0] reg_rt_id_D,
    input  logic [4:0] reg_rs_id_E,
    input  logic [4:0] reg_rt_id_E,
    input  logic [4:0] write_reg_E,
    input  logic [4:0] write_reg_M,
    input  logic [4:0] write_reg_W,
    input  logic       reg_write_E,
    input  logic       reg_write_M,
    input  logic       reg_write_W,
    input  logic       mem_to_reg_E,
    input  logic       mem_to_reg_M,
    input  logic       branch_D,
    input  logic       jump_reg_D,
    input  logic       jump_D,
    input  logic       hilo_use_D,
    input  logic       muldiv_start_E,
    input  logic       muldiv_is_div_E,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       flush_E,
    output logic       forward_a_D,
    output logic       forward_b_D,
    output logic [1:0] forward_a_E,
    output logic [1:0] forward_b_E,
    output logic       muldiv_busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CNT_W-1:0] load_val;

    // Stage write-ports that can act as a hazard/forwarding source (never r0)
    logic src_E, src_M, src_W, src_M_load;
    logic lw_stall, br_stall, hl_stall, stall;
    logic br_E, br_M;

    assign src_E      = reg_write_E && (write_reg_E != 5'd0);
    assign src_M      = reg_write_M && (write_reg_M != 5'd0);
    assign src_W      = reg_write_W && (write_reg_W != 5'd0);
    assign src_M_load = src_M && mem_to_reg_M;

    // State and countdown register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // Next-state: a load of 0 (latency 1) never enters BUSY; start in BUSY is ignored
    always_comb begin
        state_n  = state;
        count_n  = count;
        load_val = muldiv_is_div_E ? DIV_LOAD : MULT_LOAD;
        case (state)
            IDLE: begin
                if (muldiv_start_E && (load_val != '0)) begin
                    state_n = BUSY;
                    count_n = load_val;
                end
            end
            BUSY: begin
                if (count <= CNT_W'(1)) begin
                    state_n = IDLE;
                    count_n = '0;
                end else begin
                    count_n = count - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

    // Hazard detection and forwarding; everything is forced low during reset
    always_comb begin
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        forward_a_D = 1'b0;
        forward_b_D = 1'b0;
        forward_a_E = 2'b00;
        forward_b_E = 2'b00;
        muldiv_busy = 1'b0;

        lw_stall = mem_to_reg_E && src_E &&
                   ((write_reg_E == reg_rs_id_D) || (write_reg_E == reg_rt_id_D));
        // rt only matters for compare-branches; jr/jalr read rs alone
        br_E = src_E &&
               ((write_reg_E == reg_rs_id_D) || (branch_D && (write_reg_E == reg_rt_id_D)));
        br_M = src_M_load &&
               ((write_reg_M == reg_rs_id_D) || (branch_D && (write_reg_M == reg_rt_id_D)));
        br_stall = (branch_D || jump_reg_D) && (br_E || br_M);
        hl_stall = hilo_use_D && ((state == BUSY) || muldiv_start_E);
        stall    = lw_stall || br_stall || hl_stall;

        if (reset_n) begin
            stall_F = stall;
            stall_D = stall;
            flush_E = stall;
            // A stalled jump is re-resolved next cycle, so it must not flush now
            flush_D = jump_D && !stall;

            forward_a_D = src_M && !mem_to_reg_M && (write_reg_M == reg_rs_id_D);
            forward_b_D = src_M && !mem_to_reg_M && (write_reg_M == reg_rt_id_D);

            if (src_M && (write_reg_M == reg_rs_id_E))      forward_a_E = 2'b10;
            else if (src_W && (write_reg_W == reg_rs_id_E)) forward_a_E = 2'b01;

            if (src_M && (write_reg_M == reg_rt_id_E))      forward_b_E = 2'b10;
            else if (src_W && (write_reg_W == reg_rt_id_E)) forward_b_E = 2'b01;

            muldiv_busy = (state == BUSY);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: the driver applies one directed
// vector per cycle and queues its hand-computed response; a monitor on the
// falling edge pops and compares the packed output vector.
module tb_hazard_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [4:0] reg_rs_id_D, reg_rt_id_D, reg_rs_id_E, reg_rt_id_E;
    logic [4:0] write_reg_E, write_reg_M, write_reg_W;
    logic       reg_write_E, reg_write_M, reg_write_W;
    logic       mem_to_reg_E, mem_to_reg_M;
    logic       branch_D, jump_reg_D, jump_D, hilo_use_D;
    logic       muldiv_start_E, muldiv_is_div_E;
    logic       stall_F, stall_D, flush_D, flush_E;
    logic       forward_a_D, forward_b_D;
    logic [1:0] forward_a_E, forward_b_E;
    logic       muldiv_busy;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    string       name_q[$];

    always #5 clock = ~clock;

    hazard_controller dut (
        .clock(clock), .reset_n(reset_n),
        .reg_rs_id_D(reg_rs_id_D), .reg_rt_id_D(reg_rt_id_D),
        .reg_rs_id_E(reg_rs_id_E), .reg_rt_id_E(reg_rt_id_E),
        .write_reg_E(write_reg_E), .write_reg_M(write_reg_M), .write_reg_W(write_reg_W),
        .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
        .mem_to_reg_E(mem_to_reg_E), .mem_to_reg_M(mem_to_reg_M),
        .branch_D(branch_D), .jump_reg_D(jump_reg_D), .jump_D(jump_D),
        .hilo_use_D(hilo_use_D),
        .muldiv_start_E(muldiv_start_E), .muldiv_is_div_E(muldiv_is_div_E),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
        .forward_a_D(forward_a_D), .forward_b_D(forward_b_D),
        .forward_a_E(forward_a_E), .forward_b_E(forward_b_E),
        .muldiv_busy(muldiv_busy)
    );

    // {stall_F, stall_D, flush_E, flush_D, fwd_a_D, fwd_b_D, fwd_a_E, fwd_b_E, busy}
    function automatic logic [10:0] e(input logic st, input logic fd, input logic fad,
                                      input logic fbd, input logic [1:0] fae,
                                      input logic [1:0] fbe, input logic busy);
        return {st, st, st, fd, fad, fbd, fae, fbe, busy};
    endfunction

    task automatic clr();
        reg_rs_id_D = 5'd0; reg_rt_id_D = 5'd0; reg_rs_id_E = 5'd0; reg_rt_id_E = 5'd0;
        write_reg_E = 5'd0; write_reg_M = 5'd0; write_reg_W = 5'd0;
        reg_write_E = 1'b0; reg_write_M = 1'b0; reg_write_W = 1'b0;
        mem_to_reg_E = 1'b0; mem_to_reg_M = 1'b0;
        branch_D = 1'b0; jump_reg_D = 1'b0; jump_D = 1'b0; hilo_use_D = 1'b0;
        muldiv_start_E = 1'b0; muldiv_is_div_E = 1'b0;
    endtask

    // Queue the expected response for the inputs now applied, then advance a cycle
    task automatic step(input string name, input logic [10:0] exp);
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clock);
        #1;
    endtask

    // Monitor: sample mid-cycle, away from the active edge
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [10:0] want, got;
            string       nm;
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {stall_F, stall_D, flush_E, flush_D, forward_a_D, forward_b_D,
                    forward_a_E, forward_b_E, muldiv_busy};
            checks = checks + 1;
            if (got !== want) begin
                failures = failures + 1;
                $display("FAIL %s: got %b required %b", nm, got, want);
            end
        end
    end

    initial begin
        clr();
        reset_n = 1'b0;
        @(posedge clock);
        #1;

        // Reset forces outputs low even with active hazards on the inputs
        write_reg_M = 5'd5; reg_write_M = 1'b1; reg_rs_id_E = 5'd5;
        mem_to_reg_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd8; reg_rt_id_D = 5'd8;
        step("reset", e(0, 0, 0, 0, 2'b00, 2'b00, 0));
        reset_n = 1'b1;
        clr();
        step("idle", e(0, 0, 0, 0, 2'b00, 2'b00, 0));

        // Execute forwarding priority
        write_reg_M = 5'd5; write_reg_W = 5'd5; reg_write_M = 1'b1; reg_write_W = 1'b1;
        reg_rs_id_E = 5'd5;
        step("fwd_mem_prio", e(0, 0, 0, 0, 2'b10, 2'b00, 0));
        reg_write_M = 1'b0;
        step("fwd_wb_no_mwrite", e(0, 0, 0, 0, 2'b01, 2'b00, 0));
        reg_write_M = 1'b1; write_reg_M = 5'd0;
        step("fwd_wb_m_zero", e(0, 0, 0, 0, 2'b01, 2'b00, 0));
        clr();
        write_reg_M = 5'd7; reg_write_M = 1'b1; reg_rs_id_E = 5'd7;
        write_reg_W = 5'd9; reg_write_W = 1'b1; reg_rt_id_E = 5'd9;
        step("fwd_split", e(0, 0, 0, 0, 2'b10, 2'b01, 0));

        // Load-use
        clr();
        mem_to_reg_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd8; reg_rt_id_D = 5'd8;
        step("load_use", e(1, 0, 0, 0, 2'b00, 2'b00, 0));
        clr();
        step("load_use_gone", e(0, 0, 0, 0, 2'b00, 2'b00, 0));
        mem_to_reg_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd0;
        step("load_r0", e(0, 0, 0, 0, 2'b00, 2'b00, 0));

        // Branch hazard against a taken jump, then re-resolve
        clr();
        branch_D = 1'b1; reg_rs_id_D = 5'd3; reg_write_E = 1'b1; write_reg_E = 5'd3;
        jump_D = 1'b1;
        step("br_stall_wins", e(1, 0, 0, 0, 2'b00, 2'b00, 0));
        reg_write_E = 1'b0; write_reg_E = 5'd0;
        write_reg_M = 5'd3; reg_write_M = 1'b1;
        step("br_resolve", e(0, 1, 1, 0, 2'b00, 2'b00, 0));
        clr();
        branch_D = 1'b1; reg_rt_id_D = 5'd4; write_reg_M = 5'd4; reg_write_M = 1'b1;
        mem_to_reg_M = 1'b1;
        step("br_load_m_rt", e(1, 0, 0, 0, 2'b00, 2'b00, 0));
        clr();
        jump_reg_D = 1'b1; reg_rs_id_D = 5'd2; reg_rt_id_D = 5'd6;
        reg_write_E = 1'b1; write_reg_E = 5'd6;
        step("jr_ignores_rt", e(0, 0, 0, 0, 2'b00, 2'b00, 0));
        reg_rs_id_D = 5'd6;
        step("jr_rs", e(1, 0, 0, 0, 2'b00, 2'b00, 0));
        clr();
        jump_D = 1'b1;
        step("jump_flush", e(0, 1, 0, 0, 2'b00, 2'b00, 0));
        clr();
        reg_rs_id_D = 5'd10; reg_rt_id_D = 5'd11; write_reg_M = 5'd11; reg_write_M = 1'b1;
        step("fwd_b_D", e(0, 0, 0, 1, 2'b00, 2'b00, 0));

        // Register zero is never a source
        clr();
        write_reg_M = 5'd0; reg_write_M = 1'b1; reg_rs_id_E = 5'd0;
        mem_to_reg_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd0; reg_rs_id_D = 5'd0;
        step("reg_zero", e(0, 0, 0, 0, 2'b00, 2'b00, 0));

        // Divide: 11 busy cycles, 12 stalled cycles
        clr();
        muldiv_start_E = 1'b1; muldiv_is_div_E = 1'b1; hilo_use_D = 1'b1;
        step("div_start", e(1, 0, 0, 0, 2'b00, 2'b00, 0));
        muldiv_start_E = 1'b0; muldiv_is_div_E = 1'b0;
        for (int i = 1; i <= 11; i++) step($sformatf("div_busy%0d", i), e(1, 0, 0, 0, 2'b00, 2'b00, 1));
        step("div_done", e(0, 0, 0, 0, 2'b00, 2'b00, 0));

        // Multiply: 3 busy cycles, 4 stalled cycles
        muldiv_start_E = 1'b1;
        step("mult_start", e(1, 0, 0, 0, 2'b00, 2'b00, 0));
        muldiv_start_E = 1'b0;
        for (int i = 1; i <= 3; i++) step($sformatf("mult_busy%0d", i), e(1, 0, 0, 0, 2'b00, 2'b00, 1));
        step("mult_done", e(0, 0, 0, 0, 2'b00, 2'b00, 0));

        // Reset during the 5th busy cycle of a divide
        clr();
        muldiv_start_E = 1'b1; muldiv_is_div_E = 1'b1;
        step("div2_start", e(0, 0, 0, 0, 2'b00, 2'b00, 0));
        muldiv_start_E = 1'b0;
        for (int i = 1; i <= 4; i++) step($sformatf("div2_busy%0d", i), e(0, 0, 0, 0, 2'b00, 2'b00, 1));
        hilo_use_D = 1'b1;
        reset_n = 1'b0;
        step("reset_mid_busy", e(0, 0, 0, 0, 2'b00, 2'b00, 0));
        reset_n = 1'b1;
        step("post_reset_hilo", e(0, 0, 0, 0, 2'b00, 2'b00, 0));
        step("post_reset_hilo2", e(0, 0, 0, 0, 2'b00, 2'b00, 0));
        clr();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            failures = failures + 1;
            $display("FAIL drain: pending %0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It generates forwarding selects for the Decode-stage comparators and Execute-stage ALU operands. It also raises stall/flush for load-use, branch/jump-register-in-Decode, taken-jump and HI/LO multiply/divide hazards. A small FSM tracks the multi-cycle mult/div unit and holds Decode while HI/LO is not ready.

Parameters:
MULT_LATENCY, 4, cycles from mult start (Execute) until HI/LO valid; legal range 1..15
DIV_LATENCY, 12, cycles from div start until HI/LO valid; legal range 1..15

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
reg_rs_id_D  input  5  rs index of instruction in Decode
reg_rt_id_D  input  5  rt index of instruction in Decode
reg_rs_id_E  input  5  rs index in Execute
reg_rt_id_E  input  5  rt index in Execute
write_reg_E  input  5  destination register in Execute
write_reg_M  input  5  destination register in Memory
write_reg_W  input  5  destination register in Writeback
reg_write_E  input  1  Execute instruction writes a register
reg_write_M  input  1  Memory instruction writes a register
reg_write_W  input  1  Writeback instruction writes a register
mem_to_reg_E  input  1  Execute instruction is a load
mem_to_reg_M  input  1  Memory instruction is a load
branch_D  input  1  Decode holds a branch that compares rs/rt
jump_reg_D  input  1  Decode holds jr/jalr (reads rs)
jump_D  input  1  Decode resolved a taken jump/branch this cycle
hilo_use_D  input  1  Decode holds mult/div/mfhi/mflo/mthi/mtlo
muldiv_start_E  input  1  Execute issues mult/div this cycle
muldiv_is_div_E  input  1  1 = div, 0 = mult (valid with start)
stall_F  output  1  hold PC
stall_D  output  1  hold Fetch/Decode register
flush_D  output  1  clear Fetch/Decode register
flush_E  output  1  insert bubble into Decode/Execute register
forward_a_D  output  1  Decode rs comparator takes Memory-stage ALU result
forward_b_D  output  1  Decode rt comparator takes Memory-stage ALU result
forward_a_E  output  2  Execute operand A: 00 regfile, 01 Writeback value, 10 Memory ALU result
forward_b_E  output  2  Execute operand B, same encoding
muldiv_busy  output  1  mult/div in progress

Behaviour:
- Register 0 is never a forwarding or hazard source; all match terms require a nonzero destination and the matching reg_write_*.
- forward_*_E: 10 if Memory matches the source; else 01 if Writeback matches; else 00. Memory has priority when both match.
- forward_*_D: 1 iff Memory matches and mem_to_reg_M=0.
- lw_stall: mem_to_reg_E and write_reg_E equals reg_rs_id_D or reg_rt_id_D.
- br_stall: (branch_D or jump_reg_D) and either of the following. (a) reg_write_E, and write_reg_E equals rs_D (or rt_D, for branch_D only). (b) mem_to_reg_M, and write_reg_M equals rs_D (or rt_D, for branch_D only).
- hl_stall: hilo_use_D and (muldiv_busy or muldiv_start_E).
- stall = lw_stall | br_stall | hl_stall; stall_F = stall_D = flush_E = stall.
- flush_D = jump_D & ~stall. Stall wins; the jump is re-resolved next cycle.
- Outputs are combinational from inputs and FSM state. No added latency.
- FSM states: IDLE, BUSY. Counter is 4 bits.
  - IDLE & muldiv_start_E: go to BUSY; count <= (is_div ? DIV_LATENCY : MULT_LATENCY) - 1.
  - If the loaded value is 0 (latency 1), remain IDLE.
  - BUSY: count decrements each cycle; at count==1, next state is IDLE with count 0.
  - muldiv_start_E while BUSY cannot occur, because hl_stall blocks it. If it does occur, it is ignored and the count is not reloaded.
- muldiv_busy = (state==BUSY).
- With latency L, a hilo_use_D instruction is stalled exactly L cycles after the start cycle, then proceeds.
- Reset: asynchronous on reset_n low. State IDLE, count 0. All outputs are forced to 0 while reset_n=0.
- Reset mid-BUSY aborts the operation. After release, no stall is produced from the FSM.

Test Plan:
- Forward priority: write_reg_M=write_reg_W=5, both reg_write=1, reg_rs_id_E=5 -> forward_a_E=10. With reg_write_M=0 -> forward_a_E=01. With write_reg_M=0 -> 01.
- Load-use: mem_to_reg_E=1, write_reg_E=8, reg_rt_id_D=8 -> stall_F=stall_D=flush_E=1 for one cycle. With write_reg_E=0 -> no stall.
- Branch hazard with a taken jump in the same cycle:
  - Setup: branch_D=1, rs_D=3, reg_write_E=1, write_reg_E=3, jump_D=1.
  - Required: stall=1, flush_D=0.
  - Next cycle, with the Execute match gone: flush_D=1, stall=0, forward_a_D=1 if write_reg_M=3 and not a load.
- Divide busy: muldiv_start_E=1, muldiv_is_div_E=1 with defaults.
  - muldiv_busy is high for 11 cycles.
  - hilo_use_D=1 asserted from the start cycle stalls exactly 12 cycles total.
  - A mult stalls exactly 4 cycles.
- Reset mid-operation: reset_n low on the 5th BUSY cycle.
  - All outputs go to 0 immediately (asynchronously).
  - After release, muldiv_busy=0 and hilo_use_D=1 produces no stall.
- Register zero: write_reg_M=0, reg_write_M=1, reg_rs_id_E=0, mem_to_reg_E=1, write_reg_E=0, rs_D=0 -> all forwards 00, no stall.
